gpu_result_port: RTL and testbench
==================================

// Module: gpu_result_port
// PURPOSE
// - Result egress stage of the tiny GPU. Accepts accumulator results from the compute core
//   over a valid/ready handshake and buffers them in a small FIFO.
// - Presents them on the result_vld/result_rdy/result_data port that the testbench driver
//   backpressures and the monitor samples.
// - Decouples core throughput from consumer stalls and counts delivered results.
// PARAMETERS
// - ACC_WIDTH   default constants_pkg::ACC_WIDTH (32)   width of one result word
// - DEPTH       default 4                               FIFO entries; power of two, >= 2
// - CNT_WIDTH   default 16                              width of delivered-result counter
// PORTS
// - clk            in   1          single clock; all state updates on posedge
// - rst_n          in   1          asynchronous, active-low reset
// - acc_vld        in   1          core offers a result this cycle
// - acc_rdy        out  1          block can accept a result (= !full)
// - acc_data       in   ACC_WIDTH  core result word
// - result_vld     out  1          result_data holds a valid word
// - result_rdy     in   1          consumer accepts; may toggle arbitrarily
// - result_data    out  ACC_WIDTH  head-of-FIFO result
// - count          out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
// - results_sent   out  CNT_WIDTH  number of completed output handshakes; wraps mod 2^CNT_WIDTH
// BEHAVIOUR
// - Reset state (async assert, sync release):
//   - result_vld=0, result_data=0, count=0, results_sent=0.
//   - Read/write pointers are 0; acc_rdy=1 (FIFO not full).
// - Push: acc_vld && acc_rdy at posedge writes acc_data at wr_ptr; wr_ptr increments mod DEPTH.
// - Pop: result_vld && result_rdy at posedge advances rd_ptr and increments results_sent.
// - Latency: a word pushed at edge N is visible on result_vld/result_data after edge N.
//   Empty-FIFO latency is therefore 1 cycle. There is no combinational acc->result path.
// - Output rules:
//   - result_vld = (count != 0).
//   - result_data = mem[rd_ptr] and must stay stable while result_vld && !result_rdy.
//   - result_vld never drops without a handshake.
// - acc_rdy = (count != DEPTH). It depends only on registered state, never on result_rdy.
// - Full + acc_vld: acc_rdy=0, so nothing is written and no data is lost.
//   A simultaneous pop frees a slot that becomes usable from the next cycle.
// - Empty + result_rdy: no pop, results_sent unchanged, result_data holds the last value.
// - Simultaneous push and pop with 0<count<DEPTH: count unchanged and both pointers advance.
// - Pointer wrap: pointers wrap DEPTH-1 -> 0. Occupancy is tracked by count, not by
//   pointer compare.
// - results_sent wraps 2^CNT_WIDTH-1 -> 0 with no flag.
// - Reset mid-operation: all buffered results are discarded immediately; outputs go to
//   reset values asynchronously.
// - X on acc_data with acc_vld=0 has no effect. result_data is never X after reset.
// STRUCTURE
// - constants_pkg (shared): ACC_WIDTH and typedef logic [ACC_WIDTH-1:0] acc_t, used by the
//   core, this block and gpu_result_if.
// - One sub-module, gpu_result_fifo: parameterised sync FIFO (mem, pointers, count, flags).
// - The top level adds the handshake wiring and the results_sent counter.
// TESTING
// - Reset then idle:
//   - After rst_n rises: result_vld=0, acc_rdy=1, count=0, results_sent=0, result_data=0.
// - Single word, result_rdy held 1:
//   - Push 32'hDEAD_BEEF at edge N; result_vld=1 with that data after N.
//   - Popped at N+1; then result_vld=0 and results_sent=1.
// - Fill with result_rdy=0:
//   - Push 1,2,3,4: count=4, acc_rdy=0.
//   - 5th offer (5) is held off; result_data stays 1 across 10 stall cycles.
//   - Release result_rdy: outputs 1,2,3,4 in order, then 5 once accepted.
// - Streaming with random result_rdy:
//   - Push 0..99 back-to-back; consumer sees 0..99 in order with no loss or duplication.
//   - results_sent=100; pointers wrap many times.
// - Simultaneous push/pop at count=2:
//   - count stays 2; order preserved.
// - Counter wrap and mid-stream reset:
//   - Force 65535 prior sends; one more pop gives results_sent=0.
//   - Asserting rst_n low with count=3 clears result_vld and count immediately.
//   - No stale word appears after release.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared GPU constants: result word width and its type, used by the core,
// the result port and the result interface.
package constants_pkg;
  localparam int ACC_WIDTH = 32;
  typedef logic [ACC_WIDTH-1:0] acc_t;
endpackage

// File: rtl/gpu_result_fifo.sv
// Small synchronous FIFO with an occupancy counter and a registered head word,
// so the output is never X and holds the last value once drained.
module gpu_result_fifo #(
  parameter int WIDTH = constants_pkg::ACC_WIDTH,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic             do_push, do_pop;

  assign full       = (count_reg == CNT_FULL);
  assign empty      = (count_reg == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign count      = count_reg;
  assign rd_data    = head_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Head register tracks mem[rd_ptr]; when the successor is being written this
  // very cycle it is taken straight from wr_data to keep one-cycle latency.
  always_comb begin
    head_next = head_reg;
    if (do_pop) begin
      if (count_reg > CNT_ONE) head_next = mem[rd_ptr_inc];
      else if (do_push)        head_next = wr_data;
    end else if (do_push && empty) begin
      head_next = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
      head_reg  <= head_next;
    end
  end
endmodule

// File: rtl/gpu_result_port.sv
// Result egress stage: buffers core results in a FIFO, presents them on a
// valid/ready port and counts completed output handshakes.
module gpu_result_port #(
  parameter int ACC_WIDTH = constants_pkg::ACC_WIDTH,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   acc_vld,
  output logic                   acc_rdy,
  input  logic [ACC_WIDTH-1:0]   acc_data,
  output logic                   result_vld,
  input  logic                   result_rdy,
  output logic [ACC_WIDTH-1:0]   result_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_WIDTH-1:0]   results_sent
);
  logic full, empty, push, pop;
  logic [CNT_WIDTH-1:0] sent_reg;

  // Both ready and valid come from registered occupancy only.
  assign acc_rdy      = !full;
  assign result_vld   = !empty;
  assign push         = acc_vld && acc_rdy;
  assign pop          = result_vld && result_rdy;
  assign results_sent = sent_reg;

  gpu_result_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (acc_data),
    .rd_data (result_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sent_reg <= '0;
    else if (pop) sent_reg <= sent_reg + 1'b1;
  end
endmodule

// File: tb/tb_gpu_result_port.sv
// Directed bench for gpu_result_port: reset, single word, fill/stall, random
// backpressure streaming, concurrent push/pop, counter wrap and async reset.
module tb_gpu_result_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        acc_vld, acc_rdy, result_vld, result_rdy;
  logic [31:0] acc_data, result_data;
  logic [2:0]  count;
  logic [15:0] results_sent;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] got_q[$];
  int          sent_m = 0;
  bit          pushed;

  always #5 clk = ~clk;

  gpu_result_port #(.ACC_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_vld      (acc_vld),
    .acc_rdy      (acc_rdy),
    .acc_data     (acc_data),
    .result_vld   (result_vld),
    .result_rdy   (result_rdy),
    .result_data  (result_data),
    .count        (count),
    .results_sent (results_sent)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Record handshakes seen just before the edge, then advance one cycle.
  task automatic tick();
    pushed = acc_vld && acc_rdy && rst_n;
    if (rst_n && result_vld && result_rdy) begin
      got_q.push_back(result_data);
      sent_m = (sent_m + 1) % 65536;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, cyc;
    rst_n = 1'b0; acc_vld = 1'b0; result_rdy = 1'b0; acc_data = 'x;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset then idle
    chk("rst_vld", result_vld, 0);
    chk("rst_acc_rdy", acc_rdy, 1);
    chk("rst_count", count, 0);
    chk("rst_sent", results_sent, 0);
    chk("rst_data", result_data, 0);
    tick();
    chk("idle_x_data", result_data, 0);

    // Single word with consumer always ready
    result_rdy = 1'b1; acc_vld = 1'b1; acc_data = 32'hDEAD_BEEF;
    tick();
    acc_vld = 1'b0; acc_data = '0;
    chk("single_vld", result_vld, 1);
    chk("single_data", result_data, 32'hDEAD_BEEF);
    tick();
    chk("single_vld_after", result_vld, 0);
    chk("single_sent", results_sent, 1);
    chk("single_hold", result_data, 32'hDEAD_BEEF);
    chk("single_seen", got_q.pop_front(), 32'hDEAD_BEEF);

    // Fill with consumer stalled
    result_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      acc_vld = 1'b1; acc_data = i; tick();
    end
    chk("fill_count", count, 4);
    chk("fill_acc_rdy", acc_rdy, 0);
    acc_data = 5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_data", result_data, 1);
    end
    chk("stall_count", count, 4);
    result_rdy = 1'b1;
    cyc = 0;
    while (got_q.size() < 5 && cyc < 30) begin
      tick();
      if (pushed) acc_vld = 1'b0;
      cyc++;
    end
    acc_vld = 1'b0;
    chk("fill_drain_n", got_q.size(), 5);
    for (int i = 1; i <= 5 && got_q.size() > 0; i++) chk("fill_order", got_q.pop_front(), i);
    tick();
    chk("fill_sent", results_sent, 6);

    // Streaming 0..99 with random backpressure
    got_q.delete();
    nxt = 0; cyc = 0;
    while (got_q.size() < 100 && cyc < 2000) begin
      acc_vld = (nxt < 100); acc_data = nxt;
      result_rdy = ($urandom_range(0, 1) == 1);
      tick();
      if (pushed) nxt++;
      cyc++;
    end
    acc_vld = 1'b0; result_rdy = 1'b0;
    chk("stream_n", got_q.size(), 100);
    for (int i = 0; i < 100 && got_q.size() > 0; i++) chk("stream_order", got_q.pop_front(), i);
    chk("stream_sent", results_sent, 106);

    // Simultaneous push and pop at count=2
    got_q.delete();
    for (int i = 0; i < 2; i++) begin
      acc_vld = 1'b1; acc_data = 32'hA0 + i; tick();
    end
    chk("pp_count_pre", count, 2);
    result_rdy = 1'b1;
    acc_data = 32'hA2; tick();
    chk("pp_count_1", count, 2);
    acc_data = 32'hA3; tick();
    chk("pp_count_2", count, 2);
    acc_vld = 1'b0;
    cyc = 0;
    while (got_q.size() < 4 && cyc < 20) begin tick(); cyc++; end
    chk("pp_n", got_q.size(), 4);
    for (int i = 0; i < 4 && got_q.size() > 0; i++) chk("pp_order", got_q.pop_front(), 32'hA0 + i);
    chk("pp_sent", results_sent, 110);

    // Counter wrap: run to 65535 sends, then one more pop
    acc_vld = 1'b1; result_rdy = 1'b1; cyc = 0;
    while (sent_m != 65535 && cyc < 70000) begin
      acc_data = cyc; tick(); cyc++;
      if (got_q.size() > 16) got_q.delete();
    end
    acc_vld = 1'b0; result_rdy = 1'b0;
    chk("wrap_reached", sent_m, 65535);
    chk("wrap_pre", results_sent, 16'hFFFF);
    chk("wrap_pending", count, 1);
    result_rdy = 1'b1; tick(); result_rdy = 1'b0;
    chk("wrap_zero", results_sent, 0);

    // Reset mid-stream with three words buffered
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      acc_vld = 1'b1; acc_data = 32'h77 + i; tick();
    end
    acc_vld = 1'b0;
    chk("mrst_count_pre", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", result_vld, 0);
    chk("mrst_count", count, 0);
    chk("mrst_data", result_data, 0);
    chk("mrst_acc_rdy", acc_rdy, 1);
    @(negedge clk) rst_n = 1'b1;
    sent_m = 0;
    @(posedge clk); #1;
    result_rdy = 1'b1;
    repeat (4) tick();
    chk("mrst_no_stale", got_q.size(), 0);
    chk("mrst_vld_after", result_vld, 0);
    chk("mrst_sent", results_sent, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
